// File: rtl/sdf_stage_ctrl.sv
// Sequencer for one radix-2 SDF FFT stage: tracks sample phase, drives butterfly/twiddle/output strobes.
// Optional sticky protocol-error flag enabled by defining SDF_STAGE_CTRL_ERR_EN.
module sdf_stage_ctrl #(
  parameter int N     = 256,
  parameter int DEPTH = 128
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           di_en,
  output logic                           busy,
  output logic                           bf_en,
  output logic                           tw_en,
  output logic [$clog2(DEPTH)-1:0]       tw_addr,
  output logic                           do_en,
  output logic                           done,
  output logic                           err
);

  localparam int LOG_N = $clog2(N);
  localparam int LOG_D = $clog2(DEPTH);

  localparam logic [LOG_N-1:0] IN_LAST  = LOG_N'(N - 1);
  localparam logic [LOG_N-1:0] IN_DEPTH = LOG_N'(DEPTH);
  localparam logic [LOG_N-1:0] IN_DLAST = LOG_N'(DEPTH - 1);
  localparam logic [LOG_D-1:0] FL_LAST  = LOG_D'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [LOG_N-1:0] in_cnt_q, in_cnt_d;
  logic [LOG_D:0]   ph_q, ph_d;
  logic [LOG_D-1:0] fl_cnt_q, fl_cnt_d;
  // b2b_q: the current RUN frame was entered back-to-back, so the previous
  // frame's last DEPTH outputs are still draining while in_cnt < DEPTH.
  logic             b2b_q, b2b_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      in_cnt_q <= '0;
      ph_q     <= '0;
      fl_cnt_q <= '0;
      b2b_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_cnt_q <= in_cnt_d;
      ph_q     <= ph_d;
      fl_cnt_q <= fl_cnt_d;
      b2b_q    <= b2b_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    in_cnt_d = in_cnt_q;
    ph_d     = ph_q;
    fl_cnt_d = fl_cnt_q;
    b2b_d    = b2b_q;
    case (state_q)
      S_IDLE: begin
        in_cnt_d = '0;
        ph_d     = '0;
        fl_cnt_d = '0;
        if (di_en) begin
          state_d  = S_RUN;
          in_cnt_d = LOG_N'(1);
          ph_d     = (LOG_D+1)'(1);
          b2b_d    = 1'b0;
        end
      end
      S_RUN: begin
        // Schedule is fixed once a frame starts: missing samples still consume a slot.
        ph_d     = ph_q + (LOG_D+1)'(1);
        in_cnt_d = in_cnt_q + LOG_N'(1);
        if (in_cnt_q == IN_LAST) begin
          state_d  = S_FLUSH;
          fl_cnt_d = '0;
        end
      end
      S_FLUSH: begin
        ph_d = ph_q + (LOG_D+1)'(1);
        if ((fl_cnt_q == '0) && di_en) begin
          // Sample 0 of the next frame arrives right after sample N-1.
          state_d  = S_RUN;
          in_cnt_d = LOG_N'(1);
          fl_cnt_d = '0;
          b2b_d    = 1'b1;
        end else if (fl_cnt_q == FL_LAST) begin
          state_d  = S_IDLE;
          ph_d     = '0;
          fl_cnt_d = '0;
        end else begin
          fl_cnt_d = fl_cnt_q + LOG_D'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    busy    = (state_q != S_IDLE);
    bf_en   = (state_q == S_RUN) && ph_q[LOG_D];
    do_en   = ((state_q == S_RUN) && ((in_cnt_q >= IN_DEPTH) || b2b_q)) ||
              (state_q == S_FLUSH);
    done    = ((state_q == S_RUN) && b2b_q && (in_cnt_q == IN_DLAST)) ||
              ((state_q == S_FLUSH) && (fl_cnt_q == FL_LAST));
    tw_en   = do_en && !bf_en;
    tw_addr = tw_en ? ph_q[LOG_D-1:0] : '0;
  end

`ifdef SDF_STAGE_CTRL_ERR_EN
  logic err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  always_comb begin
    err_d = err_q;
    if ((state_q == S_IDLE) && di_en) begin
      err_d = 1'b0;
    end else if ((state_q == S_RUN) && !di_en) begin
      err_d = 1'b1;
    end else if ((state_q == S_FLUSH) && (fl_cnt_q != '0) && di_en) begin
      err_d = 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Directed bench for sdf_stage_ctrl at N=16, DEPTH=4; expected timing written from the stage schedule.
module tb_sdf_stage_ctrl;

  localparam int N     = 16;
  localparam int DEPTH = 4;

`ifdef SDF_STAGE_CTRL_ERR_EN
  localparam bit ERR_BUILD = 1'b1;
`else
  localparam bit ERR_BUILD = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       di_en;
  logic       busy;
  logic       bf_en;
  logic       tw_en;
  logic [1:0] tw_addr;
  logic       do_en;
  logic       done;
  logic       err;

  int n_tests;
  int n_fail;
  int cur_cyc;

  sdf_stage_ctrl #(.N(N), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .di_en  (di_en),
    .busy   (busy),
    .bf_en  (bf_en),
    .tw_en  (tw_en),
    .tw_addr(tw_addr),
    .do_en  (do_en),
    .done   (done),
    .err    (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cur_cyc, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".busy"},    busy,    0);
    check_eq({tag, ".bf_en"},   bf_en,   0);
    check_eq({tag, ".tw_en"},   tw_en,   0);
    check_eq({tag, ".tw_addr"}, tw_addr, 0);
    check_eq({tag, ".do_en"},   do_en,   0);
    check_eq({tag, ".done"},    done,    0);
    check_eq({tag, ".err"},     err,     0);
  endtask

  // Drives frames back-to-back from cycle 0, with optional dropped sample and late pulse,
  // and checks every output against the nominal stage schedule each cycle.
  task automatic run_scn(input string name, input int frames, input int gap_c, input int late_c,
                         input int err_from, input logic err_at0);
    int   last_out;
    logic e_bf, e_do, e_tw, e_done, e_busy, e_err;
    logic [1:0] e_addr;
    last_out = N * frames + DEPTH - 1;
    for (int c = 0; c < N * frames + DEPTH + 2; c++) begin
      @(posedge clk);
      #1;
      di_en = ((c < N * frames) && (c != gap_c)) || (c == late_c);
      @(negedge clk);
      cur_cyc = c;
      e_bf   = (c < N * frames) && (((c / DEPTH) % 2) == 1);
      e_do   = (c >= DEPTH) && (c <= last_out);
      e_tw   = e_do && !e_bf;
      e_addr = e_tw ? 2'(c % DEPTH) : 2'd0;
      e_done = (c >= N + DEPTH - 1) && (c <= last_out) && (((c - (N + DEPTH - 1)) % N) == 0);
      e_busy = (c >= 1) && (c <= last_out);
      if (!ERR_BUILD)  e_err = 1'b0;
      else if (c == 0) e_err = err_at0;
      else             e_err = (err_from >= 0) && (c >= err_from);
      check_eq({name, ".bf_en"},   bf_en,   e_bf);
      check_eq({name, ".do_en"},   do_en,   e_do);
      check_eq({name, ".tw_en"},   tw_en,   e_tw);
      check_eq({name, ".tw_addr"}, tw_addr, e_addr);
      check_eq({name, ".done"},    done,    e_done);
      check_eq({name, ".busy"},    busy,    e_busy);
      check_eq({name, ".err"},     err,     e_err);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cur_cyc = -1;
    rst_n   = 1'b0;
    di_en   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset_idle");

    run_scn("single",     1, -1, -1, -1, 1'b0);
    run_scn("b2b",        2, -1, -1, -1, 1'b0);
    run_scn("gap6",       1,  6, -1,  7, 1'b0);
    run_scn("late18",     1, -1, 18, 19, 1'b1);

    // Mid-frame asynchronous reset at cycle 10, then a fresh frame.
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      di_en = 1'b1;
    end
    @(posedge clk);
    #1;
    cur_cyc = 10;
    check_eq("pre_rst.do_en", do_en, 1);
    check_eq("pre_rst.busy",  busy,  1);
    rst_n = 1'b0;
    di_en = 1'b0;
    #1;
    check_all_zero("mid_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("mid_rst_hold");
    rst_n = 1'b1;
    run_scn("after_rst",  1, -1, -1, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
